// File: rtl/decpri_seq_if.sv
// Code stream handshake into the sequential decoder: a 2-bit code with valid/ready.
interface decpri_seq_if;
    logic [1:0] code;
    logic       valid;
    logic       ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/decpri_seq.sv
// Buffered 2-to-4 decoder: queues incoming codes and plays each one as a
// one-hot word held for HOLD enabled cycles, back-to-back with no gap.
module decpri_seq #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          en,
    decpri_seq_if.slave   s,
    output logic [3:0]    y,
    output logic          busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, DRIVE} state_t;

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    state_t        r_state, w_state_nx;
    logic [7:0]    r_cnt, w_cnt_nx;
    logic [3:0]    r_y, w_y_nx;
    logic          w_push, w_pop, w_has_data;
    logic [1:0]    w_head;

    // ready looks only at count, so a full FIFO stays closed even on a pop cycle
    assign s.ready    = (r_count != (AW+1)'(DEPTH));
    assign w_push     = s.valid && s.ready;
    assign w_has_data = (r_count != '0);
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= s.code;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_y     <= w_y_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_y_nx     = r_y;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_y_nx = 4'b0000;
                if (en && w_has_data) begin
                    w_pop      = 1'b1;
                    w_y_nx     = 4'b0001 << w_head;
                    w_cnt_nx   = 8'(HOLD - 1);
                    w_state_nx = DRIVE;
                end
            end
            DRIVE: begin
                // en low freezes everything so playback resumes mid-word
                if (en) begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end else if (w_has_data) begin
                        w_pop    = 1'b1;
                        w_y_nx   = 4'b0001 << w_head;
                        w_cnt_nx = 8'(HOLD - 1);
                    end else begin
                        w_y_nx     = 4'b0000;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign y    = en ? r_y : 4'b0000;
    assign busy = (r_state == DRIVE) || w_has_data;
endmodule

// File: tb/tb_decpri_seq.sv
// Scoreboard bench: a HOLD=4 and a HOLD=1 decoder share clock, reset and enable.
module tb_decpri_seq;
    localparam int HOLD0 = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] y0, y1;
    logic       busy0, busy1;

    decpri_seq_if if0 ();
    decpri_seq_if if1 ();

    decpri_seq #(.HOLD(HOLD0), .DEPTH(DEPTH)) dut0 (
        .clock(clock), .reset_n(reset_n), .en(en), .s(if0), .y(y0), .busy(busy0));
    decpri_seq #(.HOLD(1), .DEPTH(DEPTH)) dut1 (
        .clock(clock), .reset_n(reset_n), .en(en), .s(if1), .y(y1), .busy(busy1));

    always #5 clock = ~clock;

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int         run0 = 0;
    logic [3:0] cur0 = '0;
    bit         started1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mon0();
        if (!en) begin
            chk("y0_gated", 32'(y0), 0);
        end else if (y0 == 4'b0000) begin
            if (run0 > 0) chk("y0_hold_len", run0, HOLD0);
            run0 = 0;
        end else if (run0 == 0 || run0 == HOLD0) begin
            if (q0.size() == 0) chk("y0_unexpected", 32'(y0), 0);
            else begin
                cur0 = q0.pop_front();
                chk("y0_word", 32'(y0), 32'(cur0));
            end
            run0 = 1;
        end else begin
            chk("y0_hold_val", 32'(y0), 32'(cur0));
            run0++;
        end
        chk("busy0", 32'(busy0), 32'(q0.size() != 0 || run0 != 0));
    endtask

    task automatic mon1();
        logic [3:0] e;
        if (y1 != 4'b0000) begin
            if (q1.size() == 0) chk("y1_unexpected", 32'(y1), 0);
            else begin
                e = q1.pop_front();
                chk("y1_word", 32'(y1), 32'(e));
                started1 = 1'b1;
            end
        end else if (en && started1 && q1.size() != 0) begin
            chk("y1_gap", 32'(y1), 32'(q1[0]));
        end
    endtask

    // Inputs are stable across the posedge; outputs are sampled on the negedge.
    task automatic tick();
        logic xr0, xr1;
        xr0 = (q0.size() != DEPTH);
        xr1 = (q1.size() != DEPTH);
        chk("ready0", 32'(if0.ready), 32'(xr0));
        chk("ready1", 32'(if1.ready), 32'(xr1));
        if (if0.valid && xr0) q0.push_back(4'b0001 << if0.code);
        if (if1.valid && xr1) q1.push_back(4'b0001 << if1.code);
        @(posedge clock);
        @(negedge clock);
        mon0();
        mon1();
    endtask

    task automatic push0(input logic [1:0] c);
        if0.code = c; if0.valid = 1'b1; tick(); if0.valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1;
        if0.code = '0; if0.valid = 1'b0;
        if1.code = '0; if1.valid = 1'b0;
        #3;
        chk("rst_y0", 32'(y0), 0);
        chk("rst_ready0", 32'(if0.ready), 1);
        chk("rst_busy0", 32'(busy0), 0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        tick();

        // single code, latency and hold length
        push0(2'd2);
        chk("t1_lat0", 32'(y0), 0);
        tick();
        chk("t1_lat1", 32'(y0), 32'(4'b0100));
        repeat (7) tick();
        chk("t1_idle_y", 32'(y0), 0);
        chk("t1_idle_busy", 32'(busy0), 0);

        // back-to-back codes
        for (int i = 0; i < 4; i++) begin
            if0.code = 2'(i); if0.valid = 1'b1; tick();
        end
        if0.valid = 1'b0;
        repeat (18) tick();

        // fill while disabled, fifth code dropped
        en = 1'b0;
        push0(2'd3); push0(2'd3); push0(2'd1); push0(2'd0);
        chk("t3_full", 32'(if0.ready), 0);
        push0(2'd2);
        tick();
        en = 1'b1;
        repeat (20) tick();

        // pause mid-word
        push0(2'd1);
        tick(); tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (6) tick();

        // async reset during playback with codes queued
        push0(2'd3); push0(2'd2); push0(2'd1);
        tick();
        chk("t5_pre_y", 32'(y0), 32'(4'b1000));
        chk("t5_pre_q", q0.size(), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_y0", 32'(y0), 0);
        chk("t5_ready0", 32'(if0.ready), 1);
        chk("t5_busy0", 32'(busy0), 0);
        q0.delete(); run0 = 0;
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        repeat (10) tick();

        // HOLD=1 instance
        if1.code = 2'd2; if1.valid = 1'b1; tick();
        if1.code = 2'd0; tick();
        if1.code = 2'd3; tick();
        if1.valid = 1'b0;
        repeat (4) tick();
        chk("t6_y1_end", 32'(y1), 0);
        chk("t6_busy1", 32'(busy1), 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/decpri_seq.md
Name: decpri_seq

Overview:
- Buffered, sequential 2-to-4 decoder; the decoding counterpart of the 4-input priority encoder (codpri).
- Accepts a stream of 2-bit codes over a valid/ready handshake and queues them in a small FIFO.
- Plays each code out on a one-hot 4-bit output held for HOLD cycles.
- Used to turn encoded requests back into per-line strobes (e.g. LED/line select) downstream of the encoder.

Parameters:
- HOLD, 4, cycles each one-hot word is held on y (legal: 1..255).
- DEPTH, 4, FIFO entries (power of 2, >= 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  output enable; 0 freezes playback and forces y = 0000.
- code  in  2  encoded index to decode (0..3).
- valid  in  1  code is valid this cycle.
- ready  out  1  FIFO can accept; transfer on the clock edge with valid && ready.
- y  out  4  one-hot decoded output; bit[code] = 1 while that code is played.
- busy  out  1  1 while in DRIVE or the FIFO is non-empty.

Behaviour:
- Reset (reset_n = 0, asynchronous, any time including mid-playback):
  - FIFO emptied; FSM to IDLE; hold counter = 0.
  - y = 0000, busy = 0, ready = 1 (ready is combinational from count).
  - Takes effect immediately, not at the next edge.
- FIFO:
  - count 0..DEPTH; ready = (count != DEPTH). Registered pointers wrap modulo DEPTH.
  - Push on edge when valid && ready.
  - Pop is FSM-driven (below). Simultaneous push and pop: count unchanged, both take effect.
  - When full, ready = 0 even if a pop occurs in the same cycle (no fall-through).
  - valid while ready = 0: code ignored, not stored.
- FSM states: IDLE, DRIVE.
  - IDLE: if en = 1 and count > 0 → pop head, y_reg <= 1 << head, cnt <= HOLD-1, go DRIVE. Otherwise y_reg = 0000.
  - DRIVE, en = 1, cnt > 0: cnt <= cnt-1.
  - DRIVE, en = 1, cnt = 0, count > 0: pop next code back-to-back. y_reg <= 1 << head, cnt <= HOLD-1, stay in DRIVE. No gap cycle between codes.
  - DRIVE, en = 1, cnt = 0, count = 0: y_reg <= 0000, go IDLE.
  - DRIVE, en = 0: state, cnt and y_reg frozen. Playback resumes where it stopped when en returns to 1.
- Output: y = en ? y_reg : 4'b0000 (combinational gate, matches encoder enable semantics). y is always 0000 or exactly one bit set.
- Latency: code pushed at edge k into an empty FIFO in IDLE with en = 1 → y one-hot after edge k+1, held exactly HOLD cycles of en = 1.
- Same-edge push and pop in IDLE: new code is written at edge k; it is popped at edge k+1 (the FIFO does not bypass).
- HOLD = 1: each code is shown for one cycle, back-to-back.
- Counter width: 8 bits (covers HOLD up to 255).
- busy = (state == DRIVE) || (count != 0).

Test Plan:
1. Reset, then push code=2 once with en=1, HOLD=4 → y=0100 for exactly 4 cycles starting the edge after the push, then y=0000, busy=0.
2. Push codes 0,1,2,3 on consecutive cycles → y sequence 0001, 0010, 0100, 1000, 4 cycles each with no gap; ready stays 1 throughout (count never reaches 4).
3. Fill with en=0: push 3,3,1,0,2 → ready=0 after the 4th push; 5th code is dropped; y=0000 throughout. Raise en → plays 1000, 1000, 0010, 0001 only.
4. Drop en for 3 cycles in the middle of code=1 playback → y=0000 during the pause. On resume y=0010 for the remaining cycles; total en=1 cycles showing 0010 = 4.
5. Assert reset_n=0 asynchronously during playback of code=3 with 2 codes queued → y=0000, ready=1, busy=0 immediately. After release, no stale code is played.
6. HOLD=1 instance, push 2,0,3 back-to-back → y=0100, 0001, 1000 on three consecutive cycles, then 0000.
